fp_mant_mul_seq: RTL and testbench
==================================

FP_MANT_MUL_SEQ -- requirements
Module: fp_mant_mul_seq

Interface
REQ-001 Parameters: none; all widths SHALL come from package constants (LIMB_W=13, N_LIMB=5, MANT_W=53, PROD_W=106, ACC_W=130).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request a multiply; sampled only in IDLE or DONE.
REQ-005 a  input  53  mantissa A (hidden bit included), sampled on accepted start.
REQ-006 b  input  53  mantissa B, sampled on accepted start.
REQ-007 busy  output  1  high while an operation is in progress (RUN).
REQ-008 done  output  1  one-cycle pulse; p is valid from this cycle.
REQ-009 p  output  106  unsigned product a*b, held until the next accepted start or reset.

Function
REQ-010 The block SHALL compute the 53x53 product by time-multiplexing one 13x13 multiplier over 5x5 limb pairs.
REQ-011 Operands SHALL be zero-extended to 65 bits and split into limbs a_i = a[13i+12:13i], i = 0..4 (likewise b_j).
REQ-012 FSM states SHALL be IDLE, RUN and DONE; the reset state is IDLE.
REQ-013 IDLE->RUN on start=1: latch a and b, clear the accumulator, set i=j=0.
REQ-014 In each RUN cycle the block SHALL add a_i*b_j << 13*(i+j) into the 130-bit accumulator, with the multiplier combinational within that cycle.
REQ-015 Issue order SHALL be j inner, i outer (i,j) = (0,0),(0,1)..(4,4); exactly 25 RUN cycles.
REQ-016 After the (4,4) cycle the FSM SHALL go to DONE; in DONE, done=1 and p = acc[105:0]. acc[129:106] is always zero and is discarded.
REQ-017 Latency: start accepted at edge N means done=1 in the cycle after edge N+25, i.e. 26 cycles from the start edge to the done cycle.
REQ-018 DONE->RUN if start=1 (back-to-back, new operands latched); otherwise DONE->IDLE.
REQ-019 start during RUN SHALL be ignored, with no effect on the operands, counters or result.
REQ-020 busy=1 exactly in RUN; done=1 exactly in DONE.
REQ-021 p SHALL be registered and update only on entry to DONE.
REQ-022 Operand changes on a and b after acceptance SHALL have no effect.

Reset
REQ-023 On rst=1, asynchronously: state=IDLE, busy=0, done=0, p=0, accumulator=0, i=j=0, operand registers=0.
REQ-024 Reset in RUN SHALL abort the operation; no done pulse is produced for the aborted operation.
REQ-025 The first start after rst deasserts SHALL be accepted normally.

Structure
REQ-026 The shared package SHALL hold LIMB_W, N_LIMB, MANT_W, PROD_W, ACC_W and the state enum {IDLE, RUN, DONE}.
REQ-027 The block SHALL instantiate exactly one sub-module, vedic_13bit, as the shared limb multiplier; there SHALL be no other multipliers.
REQ-028 Limb select SHALL be a mux on i and j; the shift-add SHALL be a single 130-bit adder.

Verification
REQ-029 a=1, b=1, start pulse -> busy for 25 cycles, done on cycle 26, p=1.
REQ-030 a=b=2^53-1 -> p = 2^106 - 2^54 + 1.
REQ-031 a=2^52, b=2^52 -> p=2^104; a=0, b=any -> p=0 and done still on cycle 26.
REQ-032 start with new operands at RUN cycle 5 -> ignored; the first result is unchanged and the FSM returns to IDLE.
REQ-033 rst pulse at RUN cycle 10 -> busy=0 and p=0 immediately; no done; the next start completes correctly.
REQ-034 start held high in DONE with a=3, b=5 -> immediate RUN, done 26 cycles later with p=15; the previous p holds until then; random a/b (1000 ops) checked against a reference model.

Source files
------------

// File: rtl/fp_mant_mul_seq_pkg.sv
// rtl/fp_mant_mul_seq_pkg.sv - shared widths, state enum and limb shift helper
// Purpose: constants and types shared by the sequential mantissa multiplier.
// Ports: none (package).
package fp_mant_mul_seq_pkg;

    localparam int LIMB_W = 13;
    localparam int N_LIMB = 5;
    localparam int MANT_W = 53;
    localparam int PROD_W = 106;
    localparam int ACC_W  = 130;
    localparam int EXT_W  = LIMB_W * N_LIMB;
    localparam int IDX_W  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // 13*(i+j) built from shifts so the only multiplier stays the limb multiplier.
    function automatic logic [7:0] limb_shift(input logic [IDX_W-1:0] i,
                                              input logic [IDX_W-1:0] j);
        logic [7:0] k;
        k = 8'(i) + 8'(j);
        return (k << 3) + (k << 2) + k;
    endfunction

endpackage

// File: rtl/fp_mant_mul_seq_if.sv
// rtl/fp_mant_mul_seq_if.sv - request/result bundle of the mantissa multiplier
// Purpose: groups start/a/b (request) and busy/done/p (status/result).
// Modports: master drives start, a, b; slave drives busy, done, p.
interface fp_mant_mul_seq_if;
    import fp_mant_mul_seq_pkg::*;

    logic              start;
    logic [MANT_W-1:0] a;
    logic [MANT_W-1:0] b;
    logic              busy;
    logic              done;
    logic [PROD_W-1:0] p;

    modport master (output start, output a, output b,
                    input  busy,  input  done, input p);
    modport slave  (input  start, input  a,  input  b,
                    output busy,  output done, output p);
endinterface

// File: rtl/fp_mant_mul_seq_vedic_13bit.sv
// rtl/fp_mant_mul_seq_vedic_13bit.sv - combinational 13x13 urdhva-tiryak multiplier
// Purpose: unsigned 13x13 product formed column by column (vertical and crosswise).
// Ports: a, b - 13-bit limbs; p - 26-bit product.
module vedic_13bit
    import fp_mant_mul_seq_pkg::*;
(
    input  logic [LIMB_W-1:0]   a,
    input  logic [LIMB_W-1:0]   b,
    output logic [2*LIMB_W-1:0] p
);

    logic [5:0] col_sum;
    logic [5:0] carry;

    // Column k sums every a[i]&b[k-i] plus the carry from column k-1; at most
    // 13 ones plus a carry below 13, so 6 bits never overflow.
    always_comb begin
        p       = '0;
        carry   = '0;
        col_sum = '0;
        for (int k = 0; k < 2*LIMB_W-1; k++) begin
            col_sum = carry;
            for (int i = 0; i < LIMB_W; i++) begin
                if ((k - i) >= 0 && (k - i) < LIMB_W) begin
                    col_sum = col_sum + {5'b0, a[4'(i)] & b[4'(k - i)]};
                end
            end
            p[5'(k)] = col_sum[0];
            carry    = {1'b0, col_sum[5:1]};
        end
        p[2*LIMB_W-1] = carry[0];
    end

endmodule

// File: rtl/fp_mant_mul_seq.sv
// rtl/fp_mant_mul_seq.sv - 53x53 mantissa multiplier over one shared 13x13 multiplier
// Purpose: 25 RUN cycles accumulate a_i*b_j << 13*(i+j) (j inner, i outer).
// Ports: clk, rst (async, active-high); bus.slave: start, a, b in; busy, done, p out.
module fp_mant_mul_seq
    import fp_mant_mul_seq_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    fp_mant_mul_seq_if.slave   bus
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_LIMB - 1);

    state_t              state_q, state_d;
    logic [MANT_W-1:0]   a_q, b_q;
    logic [IDX_W-1:0]    i_q, j_q;
    logic [ACC_W-1:0]    acc_q;
    logic [PROD_W-1:0]   p_q;

    logic                load;
    logic                step;
    logic                last;

    logic [EXT_W-1:0]    a_ext, b_ext;
    logic [LIMB_W-1:0]   a_limb, b_limb;
    logic [2*LIMB_W-1:0] limb_prod;
    logic [ACC_W-1:0]    addend;
    logic [ACC_W-1:0]    acc_sum;

    assign last = (i_q == LAST_IDX) && (j_q == LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    load    = 1'b1;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    state_d = RUN;
                    load    = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign a_ext = {{(EXT_W-MANT_W){1'b0}}, a_q};
    assign b_ext = {{(EXT_W-MANT_W){1'b0}}, b_q};

    always_comb begin
        a_limb = '0;
        case (i_q)
            3'd0:    a_limb = a_ext[12:0];
            3'd1:    a_limb = a_ext[25:13];
            3'd2:    a_limb = a_ext[38:26];
            3'd3:    a_limb = a_ext[51:39];
            3'd4:    a_limb = a_ext[64:52];
            default: a_limb = '0;
        endcase
    end

    always_comb begin
        b_limb = '0;
        case (j_q)
            3'd0:    b_limb = b_ext[12:0];
            3'd1:    b_limb = b_ext[25:13];
            3'd2:    b_limb = b_ext[38:26];
            3'd3:    b_limb = b_ext[51:39];
            3'd4:    b_limb = b_ext[64:52];
            default: b_limb = '0;
        endcase
    end

    vedic_13bit u_mul (
        .a (a_limb),
        .b (b_limb),
        .p (limb_prod)
    );

    assign addend  = ACC_W'(limb_prod) << limb_shift(i_q, j_q);
    assign acc_sum = acc_q + addend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            i_q   <= '0;
            j_q   <= '0;
            acc_q <= '0;
            p_q   <= '0;
        end else if (load) begin
            a_q   <= bus.a;
            b_q   <= bus.b;
            i_q   <= '0;
            j_q   <= '0;
            acc_q <= '0;
        end else if (step) begin
            acc_q <= acc_sum;
            if (j_q == LAST_IDX) begin
                j_q <= '0;
                i_q <= last ? '0 : i_q + 1'b1;
            end else begin
                j_q <= j_q + 1'b1;
            end
            // The top 24 accumulator bits can never be set by a 53x53 product.
            if (last) begin
                p_q <= acc_sum[PROD_W-1:0];
            end
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.p    = p_q;

endmodule

// File: tb/tb_fp_mant_mul_seq.sv
// tb/tb_fp_mant_mul_seq.sv - self-checking bench for fp_mant_mul_seq
module tb_fp_mant_mul_seq;
    import fp_mant_mul_seq_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fp_mant_mul_seq_if bus ();

    fp_mant_mul_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [52:0]  a;
        logic [52:0]  b;
        logic [105:0] p;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [105:0] got, input logic [105:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Issues one op from IDLE/DONE; returns cycles to done and busy cycle count.
    task automatic run_op(input logic [52:0] x, input logic [52:0] y,
                          output int lat, output int busy_cnt);
        bus.start = 1'b1;
        bus.a     = x;
        bus.b     = y;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = ~x;
        bus.b     = ~y;
        lat       = 0;
        busy_cnt  = 0;
        for (int c = 1; c <= 60; c++) begin
            if (bus.done) begin
                lat = c;
                break;
            end
            if (bus.busy) busy_cnt++;
            @(negedge clk);
        end
        if (lat == 0) begin
            total++;
            bad++;
            $display("FAIL timeout waiting for done got=none exp=done");
        end
    endtask

    logic [105:0] held;
    logic [52:0]  ra, rb;
    int lat, bcnt;
    int rand_bad;

    initial begin
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        vecs[0] = '{53'd1, 53'd1, 106'd1};
        vecs[1] = '{{53{1'b1}}, {53{1'b1}}, 106'h3FFFFFFFFFFFFC0000000000001};
        vecs[2] = '{53'd1 << 52, 53'd1 << 52, 106'd1 << 104};
        vecs[3] = '{53'd0, 53'h1A2B3C4D5E6F7, 106'd0};
        vecs[4] = '{53'd3, 53'd5, 106'd15};
        vecs[5] = '{53'd12345, 53'd6789, 106'd83810205};
        vecs[6] = '{53'h1FFF, 53'h1FFF, 106'd67092481};
        vecs[7] = '{53'h2000, 53'h2000, 106'd67108864};

        @(negedge clk);
        @(negedge clk);
        check("reset_busy", 106'(bus.busy), 106'd0);
        check("reset_done", 106'(bus.done), 106'd0);
        check("reset_p", bus.p, 106'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            run_op(vecs[v].a, vecs[v].b, lat, bcnt);
            check($sformatf("vec%0d_p", v), bus.p, vecs[v].p);
            check($sformatf("vec%0d_latency", v), 106'(lat), 106'd26);
            check($sformatf("vec%0d_busy_cycles", v), 106'(bcnt), 106'd25);
            @(negedge clk);
            check($sformatf("vec%0d_idle_after", v), 106'({bus.busy, bus.done}), 106'd0);
        end

        // start with new operands at RUN cycle 5 is ignored
        bus.start = 1'b1; bus.a = 53'd1000; bus.b = 53'd1000;
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 1; c < 5; c++) @(negedge clk);
        bus.start = 1'b1; bus.a = 53'd7; bus.b = 53'd7;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 0;
        for (int c = 6; c <= 60; c++) begin
            if (bus.done) begin lat = c; break; end
            @(negedge clk);
        end
        check("ignore_start_latency", 106'(lat), 106'd26);
        check("ignore_start_p", bus.p, 106'd1000000);
        @(negedge clk);
        check("ignore_start_idle", 106'({bus.busy, bus.done}), 106'd0);

        // reset at RUN cycle 10 aborts the op
        bus.start = 1'b1; bus.a = 53'd99; bus.b = 53'd99;
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 1; c < 10; c++) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", 106'(bus.busy), 106'd0);
        check("abort_p", bus.p, 106'd0);
        @(negedge clk);
        rst = 1'b0;
        lat = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.done) lat = 1;
            @(negedge clk);
        end
        check("abort_no_done", 106'(lat), 106'd0);
        run_op(53'd11, 53'd13, lat, bcnt);
        check("after_abort_p", bus.p, 106'd143);
        check("after_abort_latency", 106'(lat), 106'd26);

        // back-to-back: start held in DONE
        @(negedge clk);
        run_op(53'd7, 53'd9, lat, bcnt);
        check("b2b_first_p", bus.p, 106'd63);
        bus.start = 1'b1; bus.a = 53'd3; bus.b = 53'd5;
        @(negedge clk);
        bus.start = 1'b0;
        check("b2b_immediate_run", 106'(bus.busy), 106'd1);
        held = 106'd63;
        lat  = 0;
        for (int c = 1; c <= 60; c++) begin
            if (bus.done) begin lat = c; break; end
            if (bus.p !== held) begin
                check("b2b_p_held", bus.p, held);
                held = bus.p;
            end
            @(negedge clk);
        end
        check("b2b_latency", 106'(lat), 106'd26);
        check("b2b_second_p", bus.p, 106'd15);
        @(negedge clk);

        // random operands against a wide reference product
        rand_bad = 0;
        for (int n = 0; n < 1000; n++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (n % 4 == 0) ra[52] = 1'b1;
            if (n % 3 == 0) rb[52] = 1'b1;
            run_op(ra, rb, lat, bcnt);
            total++;
            if (bus.p !== 106'(ra) * 106'(rb) || lat != 26) begin
                bad++;
                rand_bad++;
                if (rand_bad <= 10)
                    $display("FAIL rand%0d a=%h b=%h got=%h exp=%h lat=%0d", n, ra, rb,
                             bus.p, 106'(ra) * 106'(rb), lat);
            end
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
